// File: rtl/led_step_sequencer_if.sv
// Seek request handshake between a host and the LED step sequencer.
// The host raises seek_valid with a target colour; the sequencer reports status.
interface led_step_sequencer_if;
   logic       seek_valid;
   logic [2:0] seek_colour;
   logic       seek_ready;
   logic       busy;
   logic       seek_done;
   logic       seek_err;

   modport master (
      output seek_valid,
      output seek_colour,
      input  seek_ready,
      input  busy,
      input  seek_done,
      input  seek_err
   );

   modport slave (
      input  seek_valid,
      input  seek_colour,
      output seek_ready,
      output busy,
      output seek_done,
      output seek_err
   );
endinterface

// File: rtl/led_step_sequencer.sv
// Step controller for the 3-bit LED colour block: manual button,
// periodic auto stepping and seek-to-colour, all via a one-cycle step.
module led_step_sequencer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TICK_DIV        = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btn_raw_i,
   input  logic                  mode_auto_i,
   input  logic [2:0]            colour_in_i,
   output logic                  step_o,
   led_step_sequencer_if.slave   seek
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(TICK_DIV + 1);

   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      AUTO   = 2'd1,
      SEEK   = 2'd2
   } state_t;

   logic          sync1_q;
   logic          sync2_q;

   logic          deb_q;
   logic          deb_d;
   logic [DW-1:0] cnt_q;
   logic [DW-1:0] cnt_d;
   logic          press_q;
   logic          press_d;

   state_t        state_q;
   logic          step_q;
   logic          busy_q;
   logic          ready_q;
   logic          done_q;
   logic          err_q;
   logic [2:0]    tgt_q;
   logic [TW-1:0] tick_q;

   logic          legal;
   logic          tick_last;
   logic          hit;

   // Two-flop synchroniser for the asynchronous button.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Debounce next state: flip after enough consecutive differing samples.
   always_comb begin
      deb_d   = deb_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync2_q != deb_q) begin
         if (cnt_q == DEB_LAST) begin
            deb_d   = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Debounce state registers; press_q is a one-cycle rising-flip pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         deb_q   <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   // Request decode helpers.
   always_comb begin
      legal     = (seek.seek_colour != 3'd0) &&
                  (seek.seek_colour != 3'd7);
      tick_last = (tick_q == TICK_LAST);
      hit       = (colour_in_i == tgt_q);
   end

   // Main controller with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MANUAL;
         step_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         tgt_q   <= 3'd0;
         tick_q  <= '0;
      end else begin
         step_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            MANUAL: begin
               tick_q <= '0;
               if (seek.seek_valid && legal) begin
                  tgt_q   <= seek.seek_colour;
                  state_q <= SEEK;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end else if (seek.seek_valid) begin
                  err_q <= 1'b1;
               end else begin
                  step_q <= press_q;
                  if (mode_auto_i) begin
                     state_q <= AUTO;
                  end
               end
            end
            AUTO: begin
               if (seek.seek_valid && legal) begin
                  tgt_q   <= seek.seek_colour;
                  state_q <= SEEK;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  tick_q  <= '0;
               end else if (seek.seek_valid) begin
                  err_q  <= 1'b1;
                  tick_q <= tick_last ? '0 : tick_q + 1'b1;
               end else if (!mode_auto_i) begin
                  state_q <= MANUAL;
                  tick_q  <= '0;
               end else if (tick_last) begin
                  step_q <= 1'b1;
                  tick_q <= '0;
               end else begin
                  tick_q <= tick_q + 1'b1;
               end
            end
            SEEK: begin
               tick_q <= '0;
               if (step_q) begin
                  step_q <= 1'b0;
               end else if (!hit) begin
                  step_q <= 1'b1;
               end else begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= mode_auto_i ? AUTO : MANUAL;
               end
            end
            default: begin
               state_q <= MANUAL;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               tick_q  <= '0;
            end
         endcase
      end
   end

   assign step_o          = step_q;
   assign seek.busy       = busy_q;
   assign seek.seek_ready = ready_q;
   assign seek.seek_done  = done_q;
   assign seek.seek_err   = err_q;

endmodule

// File: tb/tb_led_step_sequencer.sv
// Scoreboard bench for led_step_sequencer: expected step/done/err events
// are queued with their cycle numbers and matched as the DUT emits them.
module tb_led_step_sequencer;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   localparam int K_STEP = 1;
   localparam int K_DONE = 2;
   localparam int K_ERR  = 3;

   logic       clk;
   logic       rst;
   logic       btn_raw;
   logic       mode_auto;
   logic [2:0] led;
   logic       step;
   logic       ld;
   logic [2:0] ld_val;
   logic       prev_step;
   logic [2:0] tgt_exp;

   int checks;
   int errors;
   int cyc;
   ev_t sb[$];

   led_step_sequencer_if sif ();

   led_step_sequencer #(
      .DEBOUNCE_CYCLES (4),
      .TICK_DIV        (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw_i   (btn_raw),
      .mode_auto_i (mode_auto),
      .colour_in_i (led),
      .step_o      (step),
      .seek        (sif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // LED block model: step advances colour 1..6, wrapping, 0 goes to 1.
   always @(posedge clk) begin
      if (ld) led <= ld_val;
      else if (step) led <= (led >= 3'd6) ? 3'd1 : led + 3'd1;
   end

   task automatic check(string tag, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d cyc=%0d", tag, act, exp, cyc);
      end
   endtask

   task automatic push(int k, int c);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   task automatic log_ev(int k);
      ev_t e;
      if (sb.size() == 0) begin
         check("unexpected_ev", k, 0);
      end else begin
         e = sb.pop_front();
         check("ev_kind", k, e.kind);
         check("ev_cyc", cyc, e.cyc);
      end
   endtask

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (step) begin
            check("step_gap", int'(prev_step), 0);
            log_ev(K_STEP);
         end
         if (sif.seek_done) begin
            log_ev(K_DONE);
            check("done_led", int'(led), int'(tgt_exp));
         end
         if (sif.seek_err) log_ev(K_ERR);
      end
      prev_step = step;
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_led(logic [2:0] v);
      ld = 1'b1;
      ld_val = v;
      tick(1);
      ld = 1'b0;
   endtask

   // Drive one seek request and queue the events it should produce.
   task automatic do_seek(logic [2:0] c);
      int base;
      int t;
      logic [2:0] cur;
      bit ok;
      base = cyc;
      ok = (c != 3'd0) && (c != 3'd7);
      if (ok) begin
         tgt_exp = c;
         cur = led;
         t = base + 2;
         while (cur != c) begin
            push(K_STEP, t);
            cur = (cur >= 3'd6) ? 3'd1 : cur + 3'd1;
            t += 2;
         end
         push(K_DONE, t);
      end else begin
         push(K_ERR, base + 1);
      end
      sif.seek_valid = 1'b1;
      sif.seek_colour = c;
      tick(1);
      sif.seek_valid = 1'b0;
      check("busy_acc", int'(sif.busy), ok ? 1 : 0);
      check("ready_acc", int'(sif.seek_ready), ok ? 0 : 1);
      tick(16);
      check("ready_end", int'(sif.seek_ready), 1);
   endtask

   initial begin
      int base;
      checks = 0;
      errors = 0;
      cyc = 0;
      rst = 1'b1;
      btn_raw = 1'b0;
      mode_auto = 1'b0;
      ld = 1'b0;
      ld_val = 3'd0;
      led = 3'd0;
      prev_step = 1'b0;
      tgt_exp = 3'd0;
      sif.seek_valid = 1'b0;
      sif.seek_colour = 3'd0;

      tick(2);
      check("rst_step", int'(step), 0);
      check("rst_busy", int'(sif.busy), 0);
      check("rst_ready", int'(sif.seek_ready), 1);
      check("rst_done", int'(sif.seek_done), 0);
      check("rst_err", int'(sif.seek_err), 0);
      rst = 1'b0;
      tick(3);

      // Glitch shorter than the debounce window.
      btn_raw = 1'b1;
      tick(3);
      btn_raw = 1'b0;
      tick(10);

      // Clean press: one step, 7 cycles after the rising edge.
      base = cyc;
      push(K_STEP, base + 7);
      btn_raw = 1'b1;
      tick(10);
      btn_raw = 1'b0;
      tick(12);

      // Auto mode for 45 cycles with a press inside the window.
      base = cyc;
      for (int i = 1; i <= 4; i++) push(K_STEP, base + 1 + 10 * i);
      mode_auto = 1'b1;
      tick(5);
      btn_raw = 1'b1;
      tick(10);
      btn_raw = 1'b0;
      tick(30);
      mode_auto = 1'b0;
      tick(20);

      // Seeks: forward, wrapping, already there, illegal targets.
      set_led(3'd2);
      do_seek(3'd5);
      set_led(3'd5);
      do_seek(3'd2);
      set_led(3'd3);
      do_seek(3'd3);
      do_seek(3'd7);
      do_seek(3'd0);
      set_led(3'd0);
      do_seek(3'd6);

      // Reset in the middle of a seek aborts it.
      set_led(3'd1);
      tgt_exp = 3'd4;
      base = cyc;
      push(K_STEP, base + 2);
      sif.seek_valid = 1'b1;
      sif.seek_colour = 3'd4;
      tick(1);
      sif.seek_valid = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
      check("abort_ready", int'(sif.seek_ready), 1);
      check("abort_busy", int'(sif.busy), 0);
      check("abort_step", int'(step), 0);
      rst = 1'b0;
      tick(15);

      check("sb_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
